// File: rtl/axi_ram_slave.sv
// axi_ram_slave
//   Single-beat AXI-style RAM slave with one outstanding read and one
//   outstanding write. The read and write channels run independently and
//   share only the backing store.
//
// Ports
//   aclk, areset            clock, asynchronous active-high reset
//   arid/araddr/arvalid/arready            read request channel
//   rid/rdata/rlast/rvalid/rready          read data channel (rlast == rvalid)
//   awid/awaddr/awvalid/awready            write address channel
//   wdata/wstrb/wvalid/wready              write data channel
//   bid/bvalid/bready                      write response channel
//   dbg_rd_state                           current read FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A source holds valid and its payload stable until that edge; ready
// may change freely. Every *ready and *valid output here is 0 during reset
// and stays 0 until the first edge after reset is released.
//
// Memory is indexed by addr[log2(MEM_WORDS)+1:2]; upper bits alias. Memory is
// never cleared by reset.

module axi_ram_slave #(
  parameter int MEM_WORDS = 1024,
  parameter int RD_LAT    = 2
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  dbg_rd_state
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_t;

  logic [31:0] mem [MEM_WORDS];

  // live_q holds the readies low through the reset-release cycle.
  logic live_q;

  // ---------------- read path ----------------
  rd_state_t        rd_state_q, rd_state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [3:0]       rid_q, rid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [IDX_W-1:0] ar_idx;
  logic             ar_fire;
  logic             r_fire;

  assign ar_idx       = araddr[IDX_W+1:2];
  assign arready      = live_q && (rd_state_q == R_IDLE);
  assign ar_fire      = arvalid && arready;
  assign rvalid       = (rd_state_q == R_RESP);
  assign r_fire       = rvalid && rready;
  assign rlast        = rvalid;
  assign rid          = rid_q;
  assign rdata        = rdata_q;
  assign dbg_rd_state = rd_state_q;

  always_comb begin
    rd_state_d = rd_state_q;
    cnt_d      = cnt_q;
    rd_idx_d   = rd_idx_q;
    rid_d      = rid_q;
    rdata_d    = rdata_q;
    unique case (rd_state_q)
      R_IDLE: begin
        if (ar_fire) begin
          rid_d    = arid;
          rd_idx_d = ar_idx;
          cnt_d    = CNT_INIT;
          if (RD_LAT == 1) begin
            rd_state_d = R_RESP;
            rdata_d    = mem[ar_idx];
          end else begin
            rd_state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // The count reaches 0 on this edge: capture the data now. The memory
        // read sees the value before any write committing on the same edge.
        if (cnt_q == 4'd1) begin
          rd_state_d = R_RESP;
          rdata_d    = mem[rd_idx_q];
        end
      end
      R_RESP: begin
        if (r_fire) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // ---------------- write path ----------------
  logic             aw_held_q, w_held_q, bvalid_q;
  logic [3:0]       awid_q, bid_q;
  logic [IDX_W-1:0] wr_idx_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic             aw_fire, w_fire, commit;
  logic [IDX_W-1:0] cm_idx;
  logic [3:0]       cm_id;
  logic [31:0]      cm_data;
  logic [3:0]       cm_strb;

  assign awready = live_q && !aw_held_q && !bvalid_q;
  assign wready  = live_q && !w_held_q && !bvalid_q;
  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;

  // Commit as soon as both halves are present, taking each half either from
  // its capture register or straight from the bus when it arrives this cycle.
  assign commit  = (aw_held_q || aw_fire) && (w_held_q || w_fire);
  assign cm_idx  = aw_held_q ? wr_idx_q : awaddr[IDX_W+1:2];
  assign cm_id   = aw_held_q ? awid_q : awid;
  assign cm_data = w_held_q ? wdata_q : wdata;
  assign cm_strb = w_held_q ? wstrb_q : wstrb;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      live_q     <= 1'b0;
      rd_state_q <= R_IDLE;
      cnt_q      <= '0;
      rd_idx_q   <= '0;
      rid_q      <= '0;
      rdata_q    <= '0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      awid_q     <= '0;
      bid_q      <= '0;
      wr_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      live_q     <= 1'b1;
      rd_state_q <= rd_state_d;
      cnt_q      <= cnt_d;
      rd_idx_q   <= rd_idx_d;
      rid_q      <= rid_d;
      rdata_q    <= rdata_d;
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bid_q     <= cm_id;
      end else begin
        if (aw_fire) begin
          aw_held_q <= 1'b1;
          awid_q    <= awid;
          wr_idx_q  <= awaddr[IDX_W+1:2];
        end
        if (w_fire) begin
          w_held_q <= 1'b1;
          wdata_q  <= wdata;
          wstrb_q  <= wstrb;
        end
        if (bvalid_q && bready) bvalid_q <= 1'b0;
      end
    end
  end

  // Backing store: no reset. commit cannot be true during reset because the
  // readies are low and the capture flags are cleared.
  always_ff @(posedge aclk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (cm_strb[i]) mem[cm_idx][8*i +: 8] <= cm_data[8*i +: 8];
      end
    end
  end

  // Address bits outside the word index are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{araddr[31:IDX_W+2], araddr[1:0],
                              awaddr[31:IDX_W+2], awaddr[1:0]};

endmodule

// File: tb/tb_axi_ram_slave.sv
module tb_axi_ram_slave;

  localparam int MEM_WORDS = 1024;
  localparam int RD_LAT    = 2;
  localparam int IDX_W     = $clog2(MEM_WORDS);
  localparam int BUDGET    = 50;

  // ---------------- clock / reset ----------------
  logic        aclk   = 1'b0;
  logic        areset = 1'b1;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rlast, rvalid;
  logic        rready = 1'b0;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [1:0]  dbg_rd_state;

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  axi_ram_slave #(.MEM_WORDS(MEM_WORDS), .RD_LAT(RD_LAT)) dut (
    .aclk(aclk), .areset(areset),
    .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bvalid(bvalid), .bready(bready),
    .dbg_rd_state(dbg_rd_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: no response within %0d cycles (t=%0t)", name, BUDGET, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Cycle-indexed view of the rules: a read accepted in cycle c shows rvalid
  // from cycle c+RD_LAT and returns memory as it stood at the start of cycle
  // c+RD_LAT-1; a write completes in the first cycle both halves have been
  // presented and its response is visible from the next cycle.
  logic [31:0]      model_mem [MEM_WORDS];
  bit               m_live = 0;
  bit               m_r_busy = 0;
  int               m_r_due = 0;
  logic [3:0]       m_r_id = '0;
  logic [IDX_W-1:0] m_r_idx = '0;
  logic [31:0]      m_r_data = '0;
  bit               m_aw_held = 0, m_w_held = 0, m_b_pend = 0;
  logic [3:0]       m_aw_id = '0, m_b_id = '0;
  logic [IDX_W-1:0] m_aw_idx = '0;
  logic [31:0]      m_wdata = '0;
  logic [3:0]       m_wstrb = '0;

  always @(negedge aclk) begin
    bit e_arready, e_rvalid, e_awready, e_wready;
    if (areset) begin
      check1("rst_arready", arready, 1'b0);
      check1("rst_awready", awready, 1'b0);
      check1("rst_wready", wready, 1'b0);
      check1("rst_rvalid", rvalid, 1'b0);
      check1("rst_bvalid", bvalid, 1'b0);
      check1("rst_rlast", rlast, 1'b0);
      check32("rst_rid", {28'b0, rid}, 32'h0);
      check32("rst_bid", {28'b0, bid}, 32'h0);
      check32("rst_rdata", rdata, 32'h0);
      m_live = 0; m_r_busy = 0; m_aw_held = 0; m_w_held = 0; m_b_pend = 0;
    end else begin
      e_arready = m_live && !m_r_busy;
      e_rvalid  = m_r_busy && (cyc >= m_r_due);
      e_awready = m_live && !m_aw_held && !m_b_pend;
      e_wready  = m_live && !m_w_held && !m_b_pend;
      check1("arready", arready, e_arready);
      check1("awready", awready, e_awready);
      check1("wready", wready, e_wready);
      check1("rvalid", rvalid, e_rvalid);
      check1("rlast", rlast, e_rvalid);
      if (e_rvalid) begin
        check32("rdata", rdata, m_r_data);
        check32("rid", {28'b0, rid}, {28'b0, m_r_id});
      end
      check1("bvalid", bvalid, m_b_pend);
      if (m_b_pend) check32("bid", {28'b0, bid}, {28'b0, m_b_id});

      if (e_rvalid && rready) m_r_busy = 0;
      if (e_arready && arvalid) begin
        m_r_busy = 1;
        m_r_due  = cyc + RD_LAT;
        m_r_id   = arid;
        m_r_idx  = araddr[IDX_W+1:2];
      end
      // Data capture happens before this cycle's write takes effect.
      if (m_r_busy && cyc == m_r_due - 1) m_r_data = model_mem[m_r_idx];

      if (m_b_pend && bready) m_b_pend = 0;
      if (e_awready && awvalid) begin
        m_aw_held = 1; m_aw_id = awid; m_aw_idx = awaddr[IDX_W+1:2];
      end
      if (e_wready && wvalid) begin
        m_w_held = 1; m_wdata = wdata; m_wstrb = wstrb;
      end
      if (m_aw_held && m_w_held) begin
        for (int i = 0; i < 4; i++)
          if (m_wstrb[i]) model_mem[m_aw_idx][8*i +: 8] = m_wdata[8*i +: 8];
        m_aw_held = 0; m_w_held = 0; m_b_pend = 1; m_b_id = m_aw_id;
      end
      m_live = 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // w_lead > 0: W presented that many cycles before AW; < 0: AW first.
  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [3:0] id, input int w_lead,
                           output logic [3:0] got_bid, output int b_lat);
    bit aw_done, w_done, aw_acc, w_acc;
    int t;
    awaddr = addr; awid = id; wdata = data; wstrb = strb;
    aw_done = 0; w_done = 0; t = 0;
    got_bid = 'x; b_lat = -1;
    while (!(aw_done && w_done) && t < BUDGET) begin
      awvalid = !aw_done && (t >= w_lead);
      wvalid  = !w_done && (t >= -w_lead);
      @(negedge aclk);
      aw_acc = awvalid && awready;
      w_acc  = wvalid && wready;
      tick();
      aw_done = aw_done || aw_acc;
      w_done  = w_done || w_acc;
      t++;
    end
    awvalid = 0; wvalid = 0;
    if (!(aw_done && w_done)) begin
      timeout("write_accept");
    end else begin
      bready = 1;
      b_lat = 1;
      @(negedge aclk);
      while (!bvalid && b_lat < BUDGET) begin
        b_lat++;
        tick();
        @(negedge aclk);
      end
      if (!bvalid) timeout("bvalid");
      got_bid = bid;
      tick();
      bready = 0;
    end
  endtask

  // hold = number of rvalid cycles with rready low before the accepting one.
  task automatic read_txn(input logic [31:0] addr, input logic [3:0] id, input int hold,
                          output logic [31:0] got_data, output logic [3:0] got_id,
                          output int r_lat, output int ar_wait);
    logic [31:0] first_data;
    araddr = addr; arid = id; arvalid = 1;
    rready = (hold == 0);
    ar_wait = 0; r_lat = -1; got_data = 'x; got_id = 'x;
    @(negedge aclk);
    while (!arready && ar_wait < BUDGET) begin
      ar_wait++;
      tick();
      @(negedge aclk);
    end
    if (!arready) begin
      timeout("ar_accept");
      arvalid = 0; rready = 0;
      tick();
    end else begin
      tick();
      arvalid = 0;
      r_lat = 1;
      @(negedge aclk);
      while (!rvalid && r_lat < BUDGET) begin
        r_lat++;
        tick();
        @(negedge aclk);
      end
      if (!rvalid) begin
        timeout("rvalid");
      end else begin
        first_data = rdata;
        for (int i = 1; i < hold; i++) begin
          tick();
          @(negedge aclk);
          check32("r_hold_data", rdata, first_data);
        end
        if (hold > 0) begin
          tick();
          rready = 1;
          @(negedge aclk);
        end
        got_data = rdata;
        got_id = rid;
      end
      tick();
      rready = 0;
    end
  endtask

  // ---------------- directed stimulus ----------------
  logic [3:0]  g_bid, g_rid;
  logic [31:0] g_data;
  int          g_blat, g_rlat, g_wait;

  logic [31:0] vec_addr [4] = '{32'h100, 32'h104, 32'h3FC, 32'h208};
  logic [31:0] vec_data [4] = '{32'h0000_0001, 32'h8000_0000, 32'h5A5A_0F0F, 32'hFFFF_FFFF};

  initial begin
    #2;
    check1("async_rst_arready", arready, 1'b0);
    check1("async_rst_rvalid", rvalid, 1'b0);
    repeat (3) tick();
    areset = 0;
    #1 check1("release_arready", arready, 1'b0);
    tick();
    check1("live_arready", arready, 1'b1);
    check1("live_awready", awready, 1'b1);

    // Basic write then read with AW and W together.
    write_txn(32'h10, 32'hDEADBEEF, 4'hF, 4'd3, 0, g_bid, g_blat);
    check32("basic_bid", {28'b0, g_bid}, 32'd3);
    check32("basic_b_lat", 32'(g_blat), 32'd1);
    read_txn(32'h10, 4'd5, 0, g_data, g_rid, g_rlat, g_wait);
    check32("basic_rdata", g_data, 32'hDEADBEEF);
    check32("basic_rid", {28'b0, g_rid}, 32'd5);
    check32("basic_r_lat", 32'(g_rlat), 32'd2);

    // W three cycles ahead of AW with a partial strobe.
    write_txn(32'h20, 32'hAABBCCDD, 4'hF, 4'd1, 0, g_bid, g_blat);
    write_txn(32'h20, 32'h11223344, 4'b0101, 4'd2, 3, g_bid, g_blat);
    check32("wfirst_bid", {28'b0, g_bid}, 32'd2);
    check32("wfirst_b_lat", 32'(g_blat), 32'd1);
    read_txn(32'h20, 4'd1, 0, g_data, g_rid, g_rlat, g_wait);
    check32("strobe_rdata", g_data, 32'hAA22CC44);

    // AW ahead of W, empty strobe: response but no change.
    write_txn(32'h20, 32'hFFFFFFFF, 4'b0000, 4'd7, -2, g_bid, g_blat);
    check32("nostrb_bid", {28'b0, g_bid}, 32'd7);
    read_txn(32'h20, 4'd2, 0, g_data, g_rid, g_rlat, g_wait);
    check32("nostrb_rdata", g_data, 32'hAA22CC44);

    // Back-pressure on R, then an immediate follow-up read.
    read_txn(32'h10, 4'd9, 5, g_data, g_rid, g_rlat, g_wait);
    check32("bp_rdata", g_data, 32'hDEADBEEF);
    check32("bp_rid", {28'b0, g_rid}, 32'd9);
    read_txn(32'h20, 4'd4, 0, g_data, g_rid, g_rlat, g_wait);
    check32("bp_next_ar_wait", 32'(g_wait), 32'd0);
    check32("bp_next_rdata", g_data, 32'hAA22CC44);

    // Address wrap.
    write_txn(32'h0, 32'hA5A5A5A5, 4'hF, 4'd0, 0, g_bid, g_blat);
    read_txn(32'(MEM_WORDS * 4), 4'd6, 0, g_data, g_rid, g_rlat, g_wait);
    check32("wrap_rdata", g_data, 32'hA5A5A5A5);

    // Same-edge ordering: write committing on the capture edge is not seen.
    write_txn(32'h40, 32'h11111111, 4'hF, 4'd1, 0, g_bid, g_blat);
    fork
      read_txn(32'h40, 4'd8, 0, g_data, g_rid, g_rlat, g_wait);
      begin
        logic [3:0] b1; int l1;
        tick();
        write_txn(32'h40, 32'h22222222, 4'hF, 4'd2, 0, b1, l1);
      end
    join
    check32("same_edge_rdata", g_data, 32'h11111111);
    // A write committed one edge before the capture is seen.
    fork
      read_txn(32'h40, 4'd8, 0, g_data, g_rid, g_rlat, g_wait);
      begin
        logic [3:0] b2; int l2;
        write_txn(32'h40, 32'h33333333, 4'hF, 4'd3, 0, b2, l2);
      end
    join
    check32("earlier_edge_rdata", g_data, 32'h33333333);

    // Table of ordinary writes and readbacks.
    for (int i = 0; i < 4; i++)
      write_txn(vec_addr[i], vec_data[i], 4'hF, 4'(i + 8), (i % 3) - 1, g_bid, g_blat);
    for (int i = 0; i < 4; i++) begin
      read_txn(vec_addr[i], 4'(i), 0, g_data, g_rid, g_rlat, g_wait);
      check32("vec_rdata", g_data, vec_data[i]);
    end

    // Reset during R_WAIT with a B response pending.
    write_txn(32'h80, 32'hCAFEF00D, 4'hF, 4'd1, 0, g_bid, g_blat);
    awaddr = 32'h84; awid = 4'd2; wdata = 32'h12345678; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    araddr = 32'h80; arid = 4'd6; arvalid = 1;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    check1("pre_rst_bvalid", bvalid, 1'b1);
    check1("pre_rst_rvalid", rvalid, 1'b0);
    #1 areset = 1;
    #1;
    check1("async_rvalid", rvalid, 1'b0);
    check1("async_bvalid", bvalid, 1'b0);
    check1("async_arready", arready, 1'b0);
    repeat (2) tick();
    areset = 0;
    repeat (3) tick();
    read_txn(32'h80, 4'd3, 0, g_data, g_rid, g_rlat, g_wait);
    check32("post_rst_rdata", g_data, 32'hCAFEF00D);
    check32("post_rst_rid", {28'b0, g_rid}, 32'd3);
    read_txn(32'h84, 4'd4, 0, g_data, g_rid, g_rlat, g_wait);
    check32("post_rst_wr_kept", g_data, 32'h12345678);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
